buzzer_beep_scheduler: RTL and testbench

//  Shares the single board buzzer between 4 requesters (e.g. alarm, key-click, timer, status).

---
 rtl/buzzer_beep_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_buzzer_beep_scheduler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_beep_scheduler.sv
// Buzzer beep scheduler: fixed-priority arbitration of four requesters
// onto one buzzer pin, then playback of the owner's latched beep pattern.
module buzzer_beep_scheduler #(
  parameter int DIV_W          = 16,
  parameter int DUR_W          = 24,
  parameter int REP_W          = 4,
  parameter bit BUZZER_ACT_LOW = 1'b1
) (
  input  logic               FPGA_CLK,
  input  logic               FPGA_RST,
  input  logic [3:0]         req,
  input  logic [4*DIV_W-1:0] tone_div,
  input  logic [4*DUR_W-1:0] on_len,
  input  logic [4*DUR_W-1:0] off_len,
  input  logic [4*REP_W-1:0] reps,
  output logic [3:0]         grant,
  output logic               busy,
  output logic [3:0]         done,
  output logic               FPGA_BUZZER
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         grant_q, grant_d;
  logic [3:0]         done_q, done_d;
  logic               tone_q, tone_d;
  logic [1:0]         owner_q, owner_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DUR_W-1:0]   on_last_q, on_last_d;
  logic [DUR_W-1:0]   off_q, off_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [DIV_W-1:0]   tcnt_q, tcnt_d;

  logic [1:0]         win_idx;
  logic [DIV_W-1:0]   div_sel;
  logic [DUR_W-1:0]   on_sel;
  logic [DUR_W-1:0]   off_sel;
  logic [REP_W-1:0]   rep_sel;
  logic               owner_req;

  // Lowest-index requester wins; its config slice is picked for latching.
  always_comb begin
    win_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) win_idx = 2'(i);
    end
    div_sel = tone_div[int'(win_idx)*DIV_W +: DIV_W];
    on_sel  = on_len[int'(win_idx)*DUR_W +: DUR_W];
    off_sel = off_len[int'(win_idx)*DUR_W +: DUR_W];
    rep_sel = reps[int'(win_idx)*REP_W +: REP_W];
  end

  assign owner_req = req[owner_q];

  // Next-state and datapath updates for the pattern sequencer.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = '0;
    tone_d    = tone_q;
    owner_d   = owner_q;
    div_d     = div_q;
    on_last_d = on_last_q;
    off_d     = off_q;
    rep_d     = rep_q;
    dur_d     = dur_q;
    tcnt_d    = tcnt_q;
    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        tone_d  = 1'b0;
        if (|req) begin
          state_d   = S_ON;
          grant_d   = 4'b0001 << win_idx;
          owner_d   = win_idx;
          div_d     = div_sel;
          on_last_d = (on_sel == '0) ? '0 : on_sel - DUR_W'(1);
          off_d     = off_sel;
          rep_d     = (rep_sel == '0) ? REP_W'(1) : rep_sel;
          dur_d     = '0;
          tcnt_d    = '0;
          tone_d    = 1'b1;
        end
      end
      S_ON: begin
        if (!owner_req) begin
          state_d = S_IDLE;
          grant_d = '0;
          tone_d  = 1'b0;
          dur_d   = '0;
          tcnt_d  = '0;
        end else if (dur_q == on_last_q) begin
          dur_d  = '0;
          tcnt_d = '0;
          if (rep_q == REP_W'(1)) begin
            state_d = S_DONE;
            done_d  = grant_q;
            tone_d  = 1'b0;
          end else begin
            rep_d = rep_q - REP_W'(1);
            if (off_q == '0) begin
              state_d = S_ON;
              tone_d  = 1'b1;
            end else begin
              state_d = S_OFF;
              tone_d  = 1'b0;
            end
          end
        end else begin
          dur_d = dur_q + DUR_W'(1);
          if (div_q == '0) begin
            tone_d = 1'b1;
          end else if (tcnt_q == div_q - DIV_W'(1)) begin
            tone_d = ~tone_q;
            tcnt_d = '0;
          end else begin
            tcnt_d = tcnt_q + DIV_W'(1);
          end
        end
      end
      S_OFF: begin
        tone_d = 1'b0;
        if (!owner_req) begin
          state_d = S_IDLE;
          grant_d = '0;
          dur_d   = '0;
          tcnt_d  = '0;
        end else if (dur_q == off_q - DUR_W'(1)) begin
          state_d = S_ON;
          tone_d  = 1'b1;
          dur_d   = '0;
          tcnt_d  = '0;
        end else begin
          dur_d = dur_q + DUR_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        tone_d  = 1'b0;
        dur_d   = '0;
        tcnt_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        tone_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
    if (FPGA_RST) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      tone_q    <= 1'b0;
      owner_q   <= '0;
      div_q     <= '0;
      on_last_q <= '0;
      off_q     <= '0;
      rep_q     <= '0;
      dur_q     <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      tone_q    <= tone_d;
      owner_q   <= owner_d;
      div_q     <= div_d;
      on_last_q <= on_last_d;
      off_q     <= off_d;
      rep_q     <= rep_d;
      dur_q     <= dur_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = |grant_q;
  assign done        = done_q;
  assign FPGA_BUZZER = BUZZER_ACT_LOW ? ~tone_q : tone_q;

endmodule

// File: tb/tb_buzzer_beep_scheduler.sv
// Testbench for buzzer_beep_scheduler: directed scenarios plus randomized
// patterns compared against a per-cycle buzzer waveform model.
module tb_buzzer_beep_scheduler;

  localparam int DIV_W = 16;
  localparam int DUR_W = 24;
  localparam int REP_W = 4;

  logic               clk;
  logic               rst;
  logic [3:0]         req;
  logic [4*DIV_W-1:0] tone_div;
  logic [4*DUR_W-1:0] on_len;
  logic [4*DUR_W-1:0] off_len;
  logic [4*REP_W-1:0] reps;
  logic [3:0]         grant;
  logic               busy;
  logic [3:0]         done;
  logic               buzzer;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected "buzzer sounding" flag for every ON/OFF cycle after grant.
  bit exp_q[$];

  buzzer_beep_scheduler #(
    .DIV_W(DIV_W),
    .DUR_W(DUR_W),
    .REP_W(REP_W),
    .BUZZER_ACT_LOW(1'b1)
  ) dut (
    .FPGA_CLK(clk),
    .FPGA_RST(rst),
    .req(req),
    .tone_div(tone_div),
    .on_len(on_len),
    .off_len(off_len),
    .reps(reps),
    .grant(grant),
    .busy(busy),
    .done(done),
    .FPGA_BUZZER(buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waveform model: each repetition is max(on,1) cycles of a square wave
  // starting high with half-period div (DC when div=0), separated by off
  // silent cycles; max(reps,1) repetitions.
  function automatic void build_seq(int div, int on, int off, int rp);
    int n_on;
    int n_rep;
    n_on  = (on == 0) ? 1 : on;
    n_rep = (rp == 0) ? 1 : rp;
    exp_q.delete();
    for (int r = 0; r < n_rep; r++) begin
      for (int k = 0; k < n_on; k++) begin
        if (div == 0) exp_q.push_back(1'b1);
        else exp_q.push_back(((k / div) % 2) == 0);
      end
      if (r < n_rep - 1) begin
        for (int k = 0; k < off; k++) exp_q.push_back(1'b0);
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(int i, int div, int on, int off, int rp);
    tone_div[i*DIV_W +: DIV_W] = DIV_W'(div);
    on_len[i*DUR_W +: DUR_W]   = DUR_W'(on);
    off_len[i*DUR_W +: DUR_W]  = DUR_W'(off);
    reps[i*REP_W +: REP_W]     = REP_W'(rp);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    #12;
    rst = 1'b0;
    tick();
    n_checks++;
    if (grant !== 4'b0 || busy !== 1'b0 || done !== 4'b0 || buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle: grant=%b busy=%b done=%b bz=%b, want 0000 0 0000 1",
               grant, busy, done, buzzer);
    end
    set_cfg(0, 2, 30, 0, 1);
    req = 4'b0001;
    tick();
    n_checks++;
    if (grant !== 4'b0001 || buzzer !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pregrant: grant=%b bz=%b, want 0001 0", grant, buzzer);
    end
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (grant !== 4'b0 || busy !== 1'b0 || done !== 4'b0 || buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: grant=%b busy=%b done=%b bz=%b, want 0000 0 0000 1",
               grant, busy, done, buzzer);
    end
    req = '0;
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (grant !== 4'b0 || buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_after: grant=%b bz=%b, want 0000 1", grant, buzzer);
    end
  endtask

  task automatic test_single();
    int p;
    set_cfg(2, 3, 20, 10, 2);
    build_seq(3, 20, 10, 2);
    p = exp_q.size();
    req = 4'b0100;
    tick();
    for (int j = 0; j < p; j++) begin
      if (j > 0) tick();
      n_checks++;
      if (grant !== 4'b0100 || busy !== 1'b1 || done !== 4'b0 ||
          buzzer !== !exp_q[j]) begin
        n_fail++;
        $display("FAIL single_c%0d: grant=%b busy=%b done=%b bz=%b, want 0100 1 0000 %b",
                 j, grant, busy, done, buzzer, !exp_q[j]);
      end
    end
    tick();
    n_checks++;
    if (done !== 4'b0100 || grant !== 4'b0100 || buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: done=%b grant=%b bz=%b, want 0100 0100 1",
               done, grant, buzzer);
    end
    req = '0;
    tick();
    n_checks++;
    if (grant !== 4'b0 || busy !== 1'b0 || done !== 4'b0) begin
      n_fail++;
      $display("FAIL single_idle: grant=%b busy=%b done=%b, want 0000 0 0000",
               grant, busy, done);
    end
  endtask

  task automatic test_priority();
    int p;
    set_cfg(1, 2, 6, 3, 2);
    set_cfg(3, 1, 5, 0, 2);
    build_seq(2, 6, 3, 2);
    p = exp_q.size();
    req = 4'b1010;
    tick();
    for (int j = 0; j < p; j++) begin
      if (j > 0) tick();
      n_checks++;
      if (grant !== 4'b0010 || done !== 4'b0 || buzzer !== !exp_q[j]) begin
        n_fail++;
        $display("FAIL prio_c%0d: grant=%b done=%b bz=%b, want 0010 0000 %b",
                 j, grant, done, buzzer, !exp_q[j]);
      end
    end
    tick();
    n_checks++;
    if (done !== 4'b0010) begin
      n_fail++;
      $display("FAIL prio_done1: done=%b, want 0010", done);
    end
    req = 4'b1000;
    tick();
    n_checks++;
    if (grant !== 4'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_gap: grant=%b busy=%b, want 0000 0", grant, busy);
    end
    build_seq(1, 5, 0, 2);
    p = exp_q.size();
    tick();
    for (int j = 0; j < p; j++) begin
      if (j > 0) tick();
      n_checks++;
      if (grant !== 4'b1000 || done !== 4'b0 || buzzer !== !exp_q[j]) begin
        n_fail++;
        $display("FAIL prio3_c%0d: grant=%b done=%b bz=%b, want 1000 0000 %b",
                 j, grant, done, buzzer, !exp_q[j]);
      end
    end
    tick();
    n_checks++;
    if (done !== 4'b1000 || buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_done3: done=%b bz=%b, want 1000 1", done, buzzer);
    end
    req = '0;
    tick();
  endtask

  task automatic test_abort();
    set_cfg(3, 4, 40, 5, 3);
    set_cfg(0, 1, 3, 0, 1);
    build_seq(4, 40, 5, 3);
    req = 4'b1000;
    tick();
    for (int j = 0; j < 10; j++) begin
      if (j > 0) tick();
      n_checks++;
      if (grant !== 4'b1000 || done !== 4'b0 || buzzer !== !exp_q[j]) begin
        n_fail++;
        $display("FAIL abort_c%0d: grant=%b done=%b bz=%b, want 1000 0000 %b",
                 j, grant, done, buzzer, !exp_q[j]);
      end
      if (j == 3) req = 4'b1001;
    end
    req = 4'b0001;
    tick();
    n_checks++;
    if (grant !== 4'b0 || busy !== 1'b0 || done !== 4'b0 || buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_drop: grant=%b busy=%b done=%b bz=%b, want 0000 0 0000 1",
               grant, busy, done, buzzer);
    end
    tick();
    n_checks++;
    if (grant !== 4'b0001 || buzzer !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_regrant: grant=%b bz=%b, want 0001 0", grant, buzzer);
    end
    req = '0;
    tick();
    n_checks++;
    if (grant !== 4'b0 || done !== 4'b0 || buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_idle: grant=%b done=%b bz=%b, want 0000 0000 1",
               grant, done, buzzer);
    end
  endtask

  task automatic test_edges();
    set_cfg(1, 0, 0, 0, 0);
    req = 4'b0010;
    tick();
    n_checks++;
    if (grant !== 4'b0010 || buzzer !== 1'b0 || done !== 4'b0) begin
      n_fail++;
      $display("FAIL edge_on: grant=%b bz=%b done=%b, want 0010 0 0000",
               grant, buzzer, done);
    end
    tick();
    n_checks++;
    if (done !== 4'b0010 || buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_done: done=%b bz=%b, want 0010 1", done, buzzer);
    end
    req = '0;
    tick();
    n_checks++;
    if (grant !== 4'b0 || done !== 4'b0) begin
      n_fail++;
      $display("FAIL edge_idle: grant=%b done=%b, want 0000 0000", grant, done);
    end
    set_cfg(2, 0, 6, 0, 1);
    req = 4'b0100;
    tick();
    for (int j = 0; j < 6; j++) begin
      if (j > 0) tick();
      n_checks++;
      if (buzzer !== 1'b0 || done !== 4'b0) begin
        n_fail++;
        $display("FAIL edge_dc_c%0d: bz=%b done=%b, want 0 0000", j, buzzer, done);
      end
    end
    tick();
    n_checks++;
    if (done !== 4'b0100 || buzzer !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_dc_done: done=%b bz=%b, want 0100 1", done, buzzer);
    end
    req = '0;
    tick();
  endtask

  task automatic test_config_latch();
    int p;
    set_cfg(0, 2, 16, 4, 2);
    build_seq(2, 16, 4, 2);
    p = exp_q.size();
    req = 4'b0001;
    tick();
    for (int j = 0; j < p; j++) begin
      if (j > 0) tick();
      n_checks++;
      if (grant !== 4'b0001 || buzzer !== !exp_q[j]) begin
        n_fail++;
        $display("FAIL latch_c%0d: grant=%b bz=%b, want 0001 %b",
                 j, grant, buzzer, !exp_q[j]);
      end
      if (j == 2) set_cfg(0, 5, 3, 1, 7);
    end
    tick();
    n_checks++;
    if (done !== 4'b0001) begin
      n_fail++;
      $display("FAIL latch_done: done=%b, want 0001", done);
    end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    int d [4];
    int o [4];
    int f [4];
    int r [4];
    int win;
    int p;
    logic [3:0] mask;
    logic [3:0] want_g;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 4; i++) begin
        d[i] = $urandom_range(0, 5);
        o[i] = $urandom_range(0, 12);
        f[i] = $urandom_range(0, 8);
        r[i] = $urandom_range(0, 3);
        set_cfg(i, d[i], o[i], f[i], r[i]);
      end
      mask = 4'($urandom_range(1, 15));
      win = 0;
      for (int i = 3; i >= 0; i--) if (mask[i]) win = i;
      want_g = 4'b0;
      want_g[win] = 1'b1;
      build_seq(d[win], o[win], f[win], r[win]);
      p = exp_q.size();
      req = mask;
      tick();
      for (int j = 0; j < p; j++) begin
        if (j > 0) tick();
        n_checks++;
        if (grant !== want_g || busy !== 1'b1 || done !== 4'b0 ||
            buzzer !== !exp_q[j]) begin
          n_fail++;
          $display("FAIL rand%0d_c%0d: grant=%b busy=%b done=%b bz=%b, want %b 1 0000 %b",
                   it, j, grant, busy, done, buzzer, want_g, !exp_q[j]);
        end
        for (int i = 0; i < 4; i++) begin
          set_cfg(i, $urandom_range(0, 9), $urandom_range(0, 20),
                  $urandom_range(0, 9), $urandom_range(0, 15));
        end
      end
      tick();
      n_checks++;
      if (done !== want_g || grant !== want_g || buzzer !== 1'b1) begin
        n_fail++;
        $display("FAIL rand%0d_done: done=%b grant=%b bz=%b, want %b %b 1",
                 it, done, grant, buzzer, want_g, want_g);
      end
      req = '0;
      tick();
      n_checks++;
      if (grant !== 4'b0 || busy !== 1'b0 || done !== 4'b0) begin
        n_fail++;
        $display("FAIL rand%0d_idle: grant=%b busy=%b done=%b, want 0000 0 0000",
                 it, grant, busy, done);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    tone_div = '0;
    on_len   = '0;
    off_len  = '0;
    reps     = '0;
    test_reset();
    test_single();
    test_priority();
    test_abort();
    test_edges();
    test_config_latch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
